// File: rtl/fifo_stream_pkg.sv
// ----------------------------------------------------------------------------
// fifo_stream_pkg
//   Shared types and constants for the FIFO-to-stream reader.
//   fsr_state_e : top-level control state (normal streaming / flush drain).
//   OCC_W       : width of the output-buffer occupancy count (0..2).
// ----------------------------------------------------------------------------
package fifo_stream_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fsr_state_e;

  localparam int OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_stream_skid.sv
// ----------------------------------------------------------------------------
// fifo_stream_skid
//   Two-entry FIFO-ordered output buffer. The oldest word is always held in
//   head_q and driven straight out, so data_o and valid_o are flop outputs.
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : drop all buffered words (wins over push)
//   push_i        : write push_data_i this edge (never asserted when full)
//   push_data_i   : word to store
//   pop_i         : consumer takes the head word (qualified by valid_o)
//   occ_o         : current occupancy 0..2
//   valid_o       : buffer non-empty
//   data_o        : oldest buffered word
// ----------------------------------------------------------------------------
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [OCC_W-1:0]      occ_q,   occ_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] head_q,  head_d;
  logic [DATA_WIDTH-1:0] tail_q,  tail_d;
  logic                  do_pop;

  // Next-state of the two entries and the occupancy.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    do_pop = pop_i & valid_q;
    if (clear_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            head_d = push_data_i;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Simultaneous push and pop: the new word replaces the head.
          if (push_i && do_pop) begin
            head_d = push_data_i;
          end else if (push_i) begin
            tail_d = push_data_i;
            occ_d  = OCC_FULL;
          end else if (do_pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (do_pop) begin
            head_d = tail_q;
            occ_d  = OCC_ONE;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
    valid_d = (occ_d != OCC_EMPTY);
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = valid_q;
  assign data_o  = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a FIFO read port (empty / rden / same-cycle rdata) into a
//   valid/ready stream through a 2-entry buffer, so the FIFO pop never
//   depends on ready_i. flush_i discards buffered words and drains the FIFO.
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   fifo_empty_i    : FIFO empty flag
//   fifo_rden_o     : FIFO pop (never asserted while empty)
//   fifo_rdata_i    : FIFO head word
//   valid_o/ready_i : stream handshake, data_o is the oldest buffered word
//   flush_i         : one-cycle flush request (ignored while flushing)
//   busy_o          : high while flushing
//   flush_done_o    : one-cycle pulse when the flush completes
// Optional feature (macro FIFO_STREAM_RD_CNT_EN):
//   words_o [CNT_WIDTH-1:0] counts completed transfers, wraps, cleared by a
//   completed flush.
// ----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef FIFO_STREAM_RD_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o
`ifdef FIFO_STREAM_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_o
`endif
);

  fsr_state_e       state_q, state_d;
  logic             flush_done_q, flush_done_d;
  logic             rden_s;
  logic             push_s;
  logic             pop_s;
  logic             clear_s;
  logic [OCC_W-1:0] occ_s;
  logic             valid_s;

  // Control FSM: pop/push/clear decisions and flush sequencing.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    rden_s       = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    clear_s      = 1'b0;
    case (state_q)
      ST_RUN: begin
        rden_s = !fifo_empty_i && (occ_s < OCC_FULL);
        push_s = rden_s;
        pop_s  = ready_i;
        // A word popped in the flush cycle is discarded by the clear.
        if (flush_i) begin
          state_d = ST_FLUSH;
          clear_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        rden_s = !fifo_empty_i;
        if (fifo_empty_i) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and flush-done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  fifo_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_s),
    .push_i      (push_s),
    .push_data_i (fifo_rdata_i),
    .pop_i       (pop_s),
    .occ_o       (occ_s),
    .valid_o     (valid_s),
    .data_o      (data_o)
  );

  // Gate with rst so the FIFO is never popped while this block is held.
  assign fifo_rden_o  = rden_s & !rst;
  assign valid_o      = valid_s;
  assign busy_o       = (state_q == ST_FLUSH);
  assign flush_done_o = flush_done_q;

`ifdef FIFO_STREAM_RD_CNT_EN
  logic [CNT_WIDTH-1:0] words_q, words_d;

  // Transfer counter; a completing flush clears it.
  always_comb begin
    words_d = words_q;
    if (flush_done_d) begin
      words_d = '0;
    end else if (valid_s && ready_i && (state_q == ST_RUN)) begin
      words_d = words_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign words_o = words_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Self-checking bench. A FIFO is modelled as an array with read/write
//   indices; the expected stream is simply the FIFO write order, skipping
//   words that a flush or reset is allowed to drop.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty_i;
  logic        fifo_rden_o;
  logic [31:0] fifo_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        flush_i;
  logic        busy_o;
  logic        flush_done_o;
`ifdef FIFO_STREAM_RD_CNT_EN
  logic [3:0]  words_o;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (32)
`ifdef FIFO_STREAM_RD_CNT_EN
    ,
    .CNT_WIDTH  (4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rden_o  (fifo_rden_o),
    .fifo_rdata_i (fifo_rdata_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .flush_done_o (flush_done_o)
`ifdef FIFO_STREAM_RD_CNT_EN
    ,
    .words_o      (words_o)
`endif
  );

  // FIFO model
  logic [31:0] mem [0:4095];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int exp_idx = 0;

  assign fifo_empty_i = (rd_ptr == wr_ptr);
  assign fifo_rdata_i = mem[rd_ptr[11:0]];

  always @(posedge clk) begin
    if (fifo_rden_o) rd_ptr <= rd_ptr + 1;
  end

  int tests_run = 0;
  int fails     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor, sampled on the falling edge
  int          xfer_cnt    = 0;
  int          discard_cnt = 0;
  int          done_cnt    = 0;
  bit          prev_stall  = 1'b0;
  bit          prev_flush  = 1'b0;
  logic [31:0] prev_data   = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      exp_idx    = rd_ptr;
      prev_stall = 1'b0;
    end else begin
      check_val("no_underflow", 32'(fifo_rden_o & fifo_empty_i), 32'd0);
      if (prev_stall && !prev_flush) begin
        check_val("hold_valid", 32'(valid_o), 32'd1);
        check_val("hold_data", data_o, prev_data);
      end
      if (valid_o && ready_i) begin
        check_val("stream_data", data_o, mem[exp_idx[11:0]]);
        exp_idx++;
        xfer_cnt++;
      end
      if (busy_o && fifo_rden_o) discard_cnt++;
      if (flush_done_o) begin
        exp_idx = rd_ptr;
        done_cnt++;
      end
      prev_stall = valid_o & !ready_i;
      prev_flush = flush_i;
      prev_data  = data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int c0;
    int x0;
    int n;
    int cycles;
    logic [31:0] w;

    rst     = 1'b1;
    ready_i = 1'b0;
    flush_i = 1'b0;

    // 1: reset values, then preloaded 4,5,6 streamed out
    push_word(32'd4);
    push_word(32'd5);
    push_word(32'd6);
    tick();
    tick();
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_rden", 32'(fifo_rden_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_done", 32'(flush_done_o), 32'd0);
    check_val("rst_data", data_o, 32'd0);
    ready_i = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("t1_rden_first", 32'(fifo_rden_o), 32'd1);
    check_val("t1_valid_first", 32'(valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t1_valid", 32'(valid_o), 32'd1);
      check_val("t1_data", data_o, 32'(4 + i));
    end
    @(negedge clk);
    check_val("t1_valid_after", 32'(valid_o), 32'd0);

    // 2: stall with 8 words queued, then release
    tick();
    ready_i = 1'b0;
    base = rd_ptr;
    for (int i = 0; i < 8; i++) push_word($urandom);
    repeat (6) tick();
    check_val("t2_pops", 32'(rd_ptr - base), 32'd2);
    check_val("t2_valid", 32'(valid_o), 32'd1);
    check_val("t2_head", data_o, mem[base[11:0]]);
    check_val("t2_rden_low", 32'(fifo_rden_o), 32'd0);
    x0 = xfer_cnt;
    ready_i = 1'b1;
    repeat (8) tick();
    check_val("t2_burst", 32'(xfer_cnt - x0), 32'd8);
    check_val("t2_drained", 32'(exp_idx), 32'(wr_ptr));

    // 3: random traffic and random back-pressure
    n = 0;
    cycles = 0;
    while ((n < 1000 || exp_idx < wr_ptr) && cycles < 20000) begin
      tick();
      ready_i = 1'($urandom_range(0, 1));
      if (n < 1000 && $urandom_range(0, 1) == 1) begin
        push_word($urandom);
        n++;
      end
      cycles++;
    end
    check_val("t3_drained", 32'(exp_idx), 32'(wr_ptr));

    // 4: flush with a full buffer and 5 words left in the FIFO
    tick();
    ready_i = 1'b0;
    repeat (3) tick();
    base = rd_ptr;
    for (int i = 0; i < 7; i++) push_word($urandom);
    repeat (5) tick();
    check_val("t4_pops", 32'(rd_ptr - base), 32'd2);
    check_val("t4_valid_pre", 32'(valid_o), 32'd1);
    d0 = discard_cnt;
    c0 = done_cnt;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("t4_valid_flush", 32'(valid_o), 32'd0);
    check_val("t4_busy", 32'(busy_o), 32'd1);
    cycles = 0;
    while (busy_o && cycles < 20) begin
      tick();
      cycles++;
    end
    check_val("t4_busy_low", 32'(busy_o), 32'd0);
    tick();
    check_val("t4_discards", 32'(discard_cnt - d0), 32'd5);
    check_val("t4_done_pulses", 32'(done_cnt - c0), 32'd1);
    check_val("t4_done_low", 32'(flush_done_o), 32'd0);
    w = $urandom;
    push_word(w);
    @(negedge clk);
    check_val("t4_new_rden", 32'(fifo_rden_o), 32'd1);
    @(negedge clk);
    check_val("t4_new_valid", 32'(valid_o), 32'd1);
    check_val("t4_new_data", data_o, w);
    tick();
    ready_i = 1'b1;
    repeat (3) tick();
    check_val("t4_drained", 32'(exp_idx), 32'(wr_ptr));

    // 5: reset with a full buffer; FIFO-resident words survive
    ready_i = 1'b0;
    base = rd_ptr;
    for (int i = 0; i < 5; i++) push_word($urandom);
    repeat (5) tick();
    check_val("t5_valid_pre", 32'(valid_o), 32'd1);
    check_val("t5_pops", 32'(rd_ptr - base), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_valid", 32'(valid_o), 32'd0);
    check_val("t5_rst_rden", 32'(fifo_rden_o), 32'd0);
    check_val("t5_rst_data", data_o, 32'd0);
    check_val("t5_rst_busy", 32'(busy_o), 32'd0);
    tick();
    tick();
    @(posedge clk);
    #1 rst = 1'b0;
    ready_i = 1'b1;
    x0 = xfer_cnt;
    repeat (10) tick();
    check_val("t5_delivered", 32'(xfer_cnt - x0), 32'd3);
    check_val("t5_drained", 32'(exp_idx), 32'(wr_ptr));

`ifdef FIFO_STREAM_RD_CNT_EN
    // 6: transfer counter wrap and clear
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (3) tick();
    check_val("t6_cnt_clear0", 32'(words_o), 32'd0);
    for (int i = 0; i < 17; i++) push_word($urandom);
    repeat (25) tick();
    check_val("t6_cnt_wrap", 32'(words_o), 32'd1);
    check_val("t6_drained", 32'(exp_idx), 32'(wr_ptr));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (3) tick();
    check_val("t6_cnt_clear", 32'(words_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
